lsu_access_unit: RTL and testbench
==================================

Name: lsu_access_unit

Overview:
- Multi-cycle load/store unit placed directly downstream of the operand/immediate mux.
- Takes the sign-extended offset produced by that mux and adds it to the base register to form the effective address.
- Drives a single-outstanding request/acknowledge data-memory bus. For loads, it returns width-extracted, sign- or zero-extended data to writeback.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles mem_req may wait for mem_ack before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new access; sampled only when busy=0
is_store  input  1  1=store, 0=load
funct3  input  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
base  input  32  rs1 value
offset  input  32  operand-mux result (sign-extended immediate)
wdata  input  32  rs2 store data
busy  output  1  unit is occupied (state != IDLE)
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: misaligned, illegal funct3 or bus error
rdata  output  32  extended load result
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word-aligned address {ea[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  bus acknowledge; also qualifies mem_rdata
mem_rdata  input  32  bus read word
bus_err  output  1  timeout abort flag, valid with done

Behaviour:
- Reset values (asynchronous, active-high; applies at any time, including mid-access):
  - state=IDLE.
  - busy, done, fault, mem_req, mem_we, bus_err = 0.
  - rdata, mem_addr, mem_be, mem_wdata = 0.
  - mem_req drops immediately and no completion is reported.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1:
  - Capture ea = base+offset (mod 2^32, carry discarded), plus is_store, funct3 and wdata.
  - Check for fault:
    - illegal funct3 (load 011/110/111, store with funct3 >= 011);
    - H with ea[0]=1;
    - W with ea[1:0] != 00.
  - Fault: go to DONE with fault=1. mem_req is never asserted.
  - Otherwise: go to REQ.
- REQ:
  - mem_req=1.
  - mem_addr, mem_be, mem_we and mem_wdata are held stable until mem_ack is sampled high.
  - On ack: go to DONE. mem_req is 0 from the next cycle.
  - For loads, rdata is registered on the ack edge.
- DONE: done=1 for exactly one cycle, then IDLE. fault and bus_err are valid only while done=1 and are 0 otherwise.
- Latency:
  - start at edge N, REQ at N+1. Ack sampled at edge N+1+k gives done=1 during cycle N+2+k (k=0: same-cycle ack).
  - Faulting access: done=1 in cycle N+1.
- Handshake boundaries:
  - start while busy=1 is ignored (not queued).
  - start in the DONE cycle is ignored; a new access is accepted next cycle.
  - mem_ack outside REQ is ignored.
- Byte lanes (loads drive the same be, mem_we=0):
  - B: be = 0001 << ea[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - H: be = ea[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - W: be = 1111; mem_wdata = wdata.
- Load extraction: select byte ea[1:0] or halfword ea[1] from mem_rdata.
  - funct3 000/001: sign-extend from bit 7/15.
  - funct3 100/101: zero-extend.
  - funct3 010: whole word.
- rdata holds its value until the next successful load; stores and faults leave it unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: mem_req drops, go to DONE with fault=1 and bus_err=1, rdata unchanged.
  - An ack arriving in that same final cycle wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; bus_err is tied to 0.

Test Plan:
- LW, base=0x1000, offset=0x0000_0008, ack on first REQ cycle, mem_rdata=0xDEADBEEF:
  - mem_addr=0x1008, be=1111, we=0;
  - done 2 cycles after start; rdata=0xDEADBEEF; fault=0.
- LB vs LBU at ea=0x2003, mem_rdata=0x80112233 -> be=1000; LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
- SH, base=0x3000, offset=0xFFFF_FFFE (−2), wdata=0x0000ABCD, ack after 3 wait cycles:
  - mem_addr=0x2FFC, be=1100, mem_wdata=0xABCDABCD, we=1;
  - req held 4 cycles with stable fields; rdata unchanged.
- LW at ea=0x1002 -> no mem_req; done with fault=1 one cycle after start. Then funct3=011 load -> same fault response.
- start pulsed every cycle during a stalled access -> only the first is accepted; assert rst mid-REQ -> mem_req=0 and busy=0 immediately, no done.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> mem_req high exactly 4 cycles, then done=1, fault=1, bus_err=1.

Source files
------------

// File: rtl/lsu_access_unit.sv
// Multi-cycle load/store unit: forms ea = base + offset and drives a single-outstanding req/ack bus.
// Optional LSU_TIMEOUT_EN aborts a REQ that sees no ack within TIMEOUT_CYCLES and flags bus_err.
module lsu_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [1:0]  ea_lo;
  logic [2:0]  f3_q;
  logic [31:0] ea_next;
  logic        bad;
  logic [3:0]  be_next;
  logic [31:0] wd_next;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign ea_next = base + offset;

  always_comb begin
    bad     = 1'b0;
    be_next = 4'b1111;
    wd_next = wdata;
    if (is_store) bad = (funct3 >= 3'b011);
    else          bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    // funct3[1:0] encodes size for both signed and unsigned forms
    case (funct3[1:0])
      2'b00: begin
        be_next = 4'b0001 << ea_next[1:0];
        wd_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next = ea_next[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{wdata[15:0]}};
        if (ea_next[0]) bad = 1'b1;
      end
      2'b10: if (ea_next[1:0] != 2'b00) bad = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ea_lo     <= '0;
      f3_q      <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          mem_addr  <= {ea_next[31:2], 2'b00};
          mem_be    <= be_next;
          mem_we    <= is_store;
          mem_wdata <= wd_next;
          ea_lo     <= ea_next[1:0];
          f3_q      <= funct3;
          busy      <= 1'b1;
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            fault <= 1'b1;
          end else begin
            state   <= REQ;
            mem_req <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= DONE;
          done    <= 1'b1;
          if (!mem_we) rdata <= extract(mem_rdata, f3_q, ea_lo);
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          mem_req <= 1'b0;
          state   <= DONE;
          done    <= 1'b1;
          fault   <= 1'b1;
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_unit.sv
// Directed bench for lsu_access_unit: inputs change and outputs are sampled on the falling edge.
module tb_lsu_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] base, offset, wdata, mem_rdata;
  logic        busy, done, fault, mem_req, mem_we, bus_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  lsu_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .wdata(wdata), .busy(busy), .done(done),
    .fault(fault), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // Presents one start pulse; returns at the falling edge of the first post-start cycle.
  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f; base = b; offset = o; wdata = wd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    vec++; if ({busy, done, fault, mem_req, mem_we, bus_err} !== 6'd0) begin
      err++; $display("FAIL reset_flags: got %b want 000000", {busy, done, fault, mem_req, mem_we, bus_err}); end
    vec++; if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
      err++; $display("FAIL reset_data: got %h %h %h %b want zeros", rdata, mem_addr, mem_wdata, mem_be); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lw;
    issue(1'b0, 3'b010, 32'h1000, 32'h8, 32'h0);
    vec++; if ({busy, mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'b1111, 32'h1008}) begin
      err++; $display("FAIL lw_req: got req=%b we=%b be=%b addr=%h want 1 0 1111 1008", mem_req, mem_we, mem_be, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); mem_ack = 1'b0;
    vec++; if ({done, fault, mem_req, bus_err, rdata} !== {4'b1000, 32'hDEADBEEF}) begin
      err++; $display("FAIL lw_done: got done=%b fault=%b req=%b rdata=%h want 1 0 0 deadbeef", done, fault, mem_req, rdata); end
    @(negedge clk);
    vec++; if ({done, busy} !== 2'b00) begin
      err++; $display("FAIL lw_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_lb_lbu;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] exp_r;
      exp_r = (i == 0) ? 32'hFFFFFF80 : 32'h00000080;
      issue(1'b0, (i == 0) ? 3'b000 : 3'b100, 32'h2000, 32'h3, 32'h0);
      vec++; if ({mem_be, mem_addr} !== {4'b1000, 32'h2000}) begin
        err++; $display("FAIL lb_be[%0d]: got be=%b addr=%h want 1000 2000", i, mem_be, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h80112233;
      @(negedge clk); mem_ack = 1'b0;
      vec++; if ({done, rdata} !== {1'b1, exp_r}) begin
        err++; $display("FAIL lb_rdata[%0d]: got done=%b rdata=%h want 1 %h", i, done, rdata, exp_r); end
      @(negedge clk);
    end
  endtask

  task automatic test_sh_wait;
    issue(1'b1, 3'b001, 32'h3000, 32'hFFFFFFFE, 32'h0000ABCD);
    mem_rdata = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      vec++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                 {1'b1, 1'b1, 4'b1100, 32'h2FFC, 32'hABCDABCD}) begin
        err++; $display("FAIL sh_hold[%0d]: got req=%b we=%b be=%b addr=%h wd=%h want 1 1 1100 2ffc abcdabcd",
                        c, mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
      if (c == 3) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    vec++; if ({done, fault, mem_req, rdata} !== {3'b100, 32'h00000080}) begin
      err++; $display("FAIL sh_done: got done=%b fault=%b req=%b rdata=%h want 1 0 0 00000080", done, fault, mem_req, rdata); end
    @(negedge clk);
  endtask

  task automatic test_fault;
    logic        st [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f  [5] = '{3'b010, 3'b011, 3'b001, 3'b011, 3'b101};
    logic [31:0] b  [5] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1003};
    logic [31:0] o  [5] = '{32'h2, 32'h0, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      issue(st[i], f[i], b[i], o[i], 32'hFFFF_FFFF);
      vec++; if ({done, fault, mem_req, bus_err, rdata} !== {4'b1100, 32'h00000080}) begin
        err++; $display("FAIL fault[%0d]: got done=%b fault=%b req=%b rdata=%h want 1 1 0 00000080", i, done, fault, mem_req, rdata); end
      @(negedge clk);
      vec++; if ({done, fault, busy, mem_req} !== 4'b0000) begin
        err++; $display("FAIL fault_clear[%0d]: got done=%b fault=%b busy=%b req=%b want 0000", i, done, fault, busy, mem_req); end
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h40; offset = 32'h0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      base = 32'h80 + 32'(c * 4);
      vec++; if ({busy, mem_req, mem_addr} !== {2'b11, 32'h40}) begin
        err++; $display("FAIL stall_ignore[%0d]: got busy=%b req=%b addr=%h want 1 1 00000040", c, busy, mem_req, mem_addr); end
      @(negedge clk);
    end
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk); mem_ack = 1'b0;
    vec++; if ({done, rdata} !== {1'b1, 32'h11223344}) begin
      err++; $display("FAIL stall_done: got done=%b rdata=%h want 1 11223344", done, rdata); end
    start = 1'b1; base = 32'h100;
    @(negedge clk);
    vec++; if ({busy, mem_req, done} !== 3'b000) begin
      err++; $display("FAIL start_in_done: got busy=%b req=%b done=%b want 000", busy, mem_req, done); end
    @(negedge clk); start = 1'b0;
    vec++; if ({busy, mem_req, mem_addr} !== {2'b11, 32'h100}) begin
      err++; $display("FAIL next_accept: got busy=%b req=%b addr=%h want 1 1 00000100", busy, mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD;
    @(negedge clk);
    vec++; if ({done, rdata} !== {1'b1, 32'hAABBCCDD}) begin
      err++; $display("FAIL next_done: got done=%b rdata=%h want 1 aabbccdd", done, rdata); end
    mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    mem_ack = 1'b0;
    vec++; if ({done, busy, rdata} !== {2'b00, 32'hAABBCCDD}) begin
      err++; $display("FAIL idle_ack: got done=%b busy=%b rdata=%h want 0 0 aabbccdd", done, busy, rdata); end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
    vec++; if (mem_req !== 1'b1) begin
      err++; $display("FAIL mid_req: got req=%b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    vec++; if ({mem_req, busy, done, rdata} !== {3'b000, 32'h0}) begin
      err++; $display("FAIL mid_reset: got req=%b busy=%b done=%b rdata=%h want 0 0 0 0", mem_req, busy, done, rdata); end
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    vec++; if ({mem_req, busy, done} !== 3'b000) begin
      err++; $display("FAIL post_reset: got req=%b busy=%b done=%b want 000", mem_req, busy, done); end
  endtask

  task automatic test_lanes;
    logic        st [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f  [5] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ea [5] = '{32'h501, 32'h602, 32'h600, 32'h700, 32'h502};
    logic [31:0] wd [5] = '{32'h5A, 32'h0, 32'h0, 32'h12345678, 32'h0};
    logic [31:0] rd [5] = '{32'h0, 32'h80017FFF, 32'h80017FFF, 32'h0, 32'h00FF7F00};
    logic [3:0]  be [5] = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b0100};
    logic [31:0] we [5] = '{32'h5A5A5A5A, 32'h0, 32'h0, 32'h12345678, 32'h0};
    logic [31:0] rx [5] = '{32'h0, 32'hFFFF8001, 32'h00007FFF, 32'h00007FFF, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      issue(st[i], f[i], ea[i] + 32'h10, 32'hFFFFFFF0, wd[i]);
      vec++; if ({mem_we, mem_be, mem_wdata, mem_addr} !== {st[i], be[i], we[i], ea[i] & 32'hFFFFFFFC}) begin
        err++; $display("FAIL lane[%0d]: got we=%b be=%b wd=%h addr=%h want %b %b %h %h", i,
                        mem_we, mem_be, mem_wdata, mem_addr, st[i], be[i], we[i], ea[i] & 32'hFFFFFFFC); end
      mem_ack = 1'b1; mem_rdata = rd[i];
      @(negedge clk); mem_ack = 1'b0;
      vec++; if ({done, rdata} !== {1'b1, rx[i]}) begin
        err++; $display("FAIL lane_rdata[%0d]: got done=%b rdata=%h want 1 %h", i, done, rdata, rx[i]); end
      @(negedge clk);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    n = 0;
    issue(1'b0, 3'b010, 32'h800, 32'h0, 32'h0);
    for (int c = 0; c < 20 && mem_req; c++) begin
      n++;
      @(negedge clk);
    end
    vec++; if (n !== 4) begin
      err++; $display("FAIL timeout_len: got %0d req cycles want 4", n); end
    vec++; if ({done, fault, bus_err, rdata} !== {3'b111, 32'hFFFFFFFF}) begin
      err++; $display("FAIL timeout_done: got done=%b fault=%b bus_err=%b rdata=%h want 1 1 1 ffffffff", done, fault, bus_err, rdata); end
    @(negedge clk);
    vec++; if ({done, fault, bus_err, busy} !== 4'b0000) begin
      err++; $display("FAIL timeout_clear: got %b want 0000", {done, fault, bus_err, busy}); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; base = '0;
    offset = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset;
    test_lw;
    test_lb_lbu;
    test_sh_wait;
    test_fault;
    test_back_to_back;
    test_reset_mid;
    test_lanes;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
